// File: rtl/if_prefetch_ctrl.sv
// Instruction prefetch controller: buffers sequential fetches from an async memory in a small FIFO.
// Latency: first instruction valid one edge after reset release or two edges after a branch request.
// Backpressure: freeze holds the head; prefetch continues until the buffer is full, then mem_addr holds.
//
// Ports:
//   clk, rst_n        - single clock, asynchronous active-low reset
//   mem_addr/mem_data - byte address to the combinational instruction memory and the word it returns
//   branch_taken/addr - redirect request and target (low two address bits ignored)
//   freeze            - consumer stall; head instruction is not accepted while high
//   instr_out/pc_out  - head instruction and its fetch address + 4
//   valid_out         - head entry is valid
module if_prefetch_ctrl #(
    parameter int WIDTH        = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int FIFO_DEPTH   = 2     // power of two, at least 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic                    branch_taken,
    input  logic [ADDRESS_SIZE-1:0] branch_addr,
    input  logic                    freeze,
    output logic [WIDTH-1:0]        instr_out,
    output logic [ADDRESS_SIZE-1:0] pc_out,
    output logic                    valid_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]           DEPTH_CNT  = CW'(FIFO_DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] WORD_BYTES = ADDRESS_SIZE'(4);

    logic [ADDRESS_SIZE-1:0] fetch_pc;
    logic [ADDRESS_SIZE-1:0] buf_addr  [FIFO_DEPTH];
    logic [WIDTH-1:0]        buf_instr [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [CW-1:0]           count;
    logic                    push;
    logic                    pop;

    // Branch targets are forced word-aligned, so the two low bits never matter.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^branch_addr[1:0];

    assign mem_addr  = fetch_pc;
    assign valid_out = (count != '0);
    assign instr_out = buf_instr[rd_ptr];
    assign pc_out    = buf_addr[rd_ptr] + WORD_BYTES;

    // A branch suppresses both sides; a full buffer can still accept a fetch
    // in the cycle its head is consumed.
    assign pop  = valid_out & ~freeze & ~branch_taken;
    assign push = ~branch_taken & ((count < DEPTH_CNT) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // Cleared entries make the idle head read back as instr 0, pc 4.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_addr[i]  <= '0;
                buf_instr[i] <= '0;
            end
        end else if (branch_taken) begin
            fetch_pc <= {branch_addr[ADDRESS_SIZE-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                // Word is captured now; later changes on mem_data do not reach the buffer.
                buf_addr[wr_ptr]  <= fetch_pc;
                buf_instr[wr_ptr] <= mem_data;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + WORD_BYTES;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: doc/if_prefetch_ctrl.md
IF_PREFETCH_CTRL -- requirements
Module: if_prefetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the instruction word width in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 32, meaning the byte-address width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of prefetch buffer entries; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, width 1, the single clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port rst_n, input, width 1; reset SHALL be asynchronous and active-low.
REQ-006 SHALL have port mem_addr, output, width ADDRESS_SIZE, the byte address driven to the asynchronous instruction memory.
REQ-007 SHALL have port mem_data, input, width WIDTH, the word returned combinationally by that memory for mem_addr.
REQ-008 SHALL have port branch_taken, input, width 1, the redirect request from the execute stage.
REQ-009 SHALL have port branch_addr, input, width ADDRESS_SIZE, the redirect target.
REQ-010 SHALL have port freeze, input, width 1; when high, the consumer does not accept the head instruction.
REQ-011 SHALL have port instr_out, output, width WIDTH, the head instruction.
REQ-012 SHALL have port pc_out, output, width ADDRESS_SIZE, equal to the head fetch address + 4.
REQ-013 SHALL have port valid_out, output, width 1, high when instr_out and pc_out are valid.

Function
REQ-014 SHALL hold fetch_pc, which is word-aligned with bits [1:0] always 0, and SHALL drive mem_addr = fetch_pc combinationally.
REQ-015 SHALL hold a circular FIFO of FIFO_DEPTH entries {addr, instr}, with read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-016 SHALL set valid_out = (count != 0), and SHALL drive instr_out and pc_out from the head entry combinationally; pc_out SHALL be the head addr + 4, wrapping modulo 2^ADDRESS_SIZE.
REQ-017 SHALL define pop = valid_out & ~freeze & ~branch_taken.
REQ-018 SHALL define push = ~branch_taken & ((count < FIFO_DEPTH) | pop); a push SHALL write {fetch_pc, mem_data} at the write pointer and advance fetch_pc by 4, wrapping to 0 after the last word.
REQ-019 On push & pop in the same cycle, count SHALL stay unchanged and both pointers SHALL advance; the FIFO SHALL never overflow or underflow.
REQ-020 On branch_taken=1, at the next edge the controller SHALL clear the FIFO (count=0, pointers=0), load fetch_pc = {branch_addr[ADDRESS_SIZE-1:2], 2'b00}, and perform no push and no pop.
REQ-021 branch_taken SHALL take priority over freeze, full, and any pending push or pop.
REQ-022 After a branch, valid_out SHALL be 0 for exactly one cycle; the target instruction SHALL be at the head with valid_out=1 one edge later.
REQ-023 In steady state (no freeze, no branch), the controller SHALL deliver one instruction per cycle in sequential address order.
REQ-024 While freeze=1, the head entry SHALL remain stable and prefetch SHALL continue until count = FIFO_DEPTH; mem_addr SHALL then hold constant.
REQ-025 Entries SHALL be captured at fetch time; later changes of mem_data SHALL NOT alter buffered entries.

Reset
REQ-026 While rst_n=0, the controller SHALL set fetch_pc=0, count=0, and pointers=0; it SHALL drive valid_out=0, mem_addr=0, and instr_out and pc_out=4 from the cleared entry 0, whose contents SHALL reset to 0.
REQ-027 Reset assertion SHALL take effect immediately, mid-operation, without a clock edge, discarding buffered entries and any in-progress branch.
REQ-028 At the first edge after rst_n rises, the controller SHALL fetch address 0 and assert valid_out.

Verification
REQ-029 Reset-release scenario: memory word[n] = n; release rst_n, no freeze, no branch -> valid_out=1 from the first edge, then pc_out sequence 4, 8, 12, … and instr_out sequence 0, 1, 2, … with one per cycle and no gaps.
REQ-030 Freeze scenario: assert freeze for 5 cycles starting while the head is at addr 0x8 -> head addr stays 0x8, count reaches FIFO_DEPTH, and mem_addr holds at 0x8 + 4*FIFO_DEPTH; after release, the stream continues from 0x8 with no drop and no duplicate.
REQ-031 Branch scenario: pulse branch_taken with branch_addr=0x43 -> next cycle valid_out=0 and mem_addr=0x40; the following cycle head addr=0x40 and pc_out=0x44.
REQ-032 Branch-during-freeze scenario: assert branch_taken and freeze together while the FIFO is full -> FIFO is flushed and the target is delivered as in REQ-031, held while freeze stays high.
REQ-033 Wrap-around scenario: branch to 2^ADDRESS_SIZE-4 -> the next fetch_pc is 0 and pc_out for that head is 0.
REQ-034 Async reset scenario: drop rst_n mid-cycle while the FIFO is full -> valid_out=0 and mem_addr=0 before the next edge.
